// File: rtl/cpu_sequencer_if.sv
// Handshake bundle between the instruction register, the micro-step sequencer
// and the datapath control decode. master = sequencer, slave = its environment.
interface cpu_sequencer_if #(
    parameter int OPCODE_W = 8,
    parameter int STATE_W  = 8,
    parameter int CYCLE_W  = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                stall;
    logic                restart;
    logic [STATE_W-1:0]  state;
    logic [CYCLE_W-1:0]  cycle;
    logic                instr_done;
    logic                halted;

    modport master (
        input  opcode, stall, restart,
        output state, cycle, instr_done, halted
    );

    modport slave (
        output opcode, stall, restart,
        input  state, cycle, instr_done, halted
    );
endinterface

// File: rtl/cpu_sequencer.sv
// CPU micro-step sequencer: two fetch steps followed by class-specific steps.
// Define CPU_SEQ_FIXED_LEN_EN for legacy fixed MAX_CYCLES-length instructions.
package cpu_seq_pkg;
    localparam logic [7:0] STATE_NEXT       = 8'd0;
    localparam logic [7:0] STATE_FETCH_PC   = 8'd1;
    localparam logic [7:0] STATE_FETCH_INST = 8'd2;
    localparam logic [7:0] STATE_HALT       = 8'd3;
    localparam logic [7:0] STATE_JUMP       = 8'd4;
    localparam logic [7:0] STATE_LDI        = 8'd5;
    localparam logic [7:0] STATE_MOV_FETCH  = 8'd6;
    localparam logic [7:0] STATE_MOV_LOAD   = 8'd7;
    localparam logic [7:0] STATE_MOV_STORE  = 8'd8;
    localparam logic [7:0] STATE_OUT_A      = 8'd9;
    localparam logic [7:0] STATE_ALU_OP     = 8'd10;
    localparam logic [7:0] STATE_INC_SP     = 8'd11;
    localparam logic [7:0] STATE_FETCH_SP   = 8'd12;
    localparam logic [7:0] STATE_RET        = 8'd13;
    localparam logic [7:0] STATE_PC_STORE   = 8'd14;
    localparam logic [7:0] STATE_TMP_STORE  = 8'd15;
    localparam logic [7:0] STATE_TMP_JUMP   = 8'd16;

    // Pattern opcodes are matched first, so no exact opcode may fall inside one.
    localparam logic [7:0] PATTERN_LDI = 8'b00??_?110;
    localparam logic [7:0] PATTERN_MOV = 8'b01??_????;
    localparam logic [7:0] PATTERN_ALU = 8'b10??_????;
    localparam logic [7:0] PATTERN_JMP = 8'b11??_?010;
    localparam logic [7:0] OP_HLT      = 8'b1111_0110;
    localparam logic [7:0] OP_OUT      = 8'b1101_0011;
    localparam logic [7:0] OP_RET      = 8'b1100_1001;
    localparam logic [7:0] OP_CALL     = 8'b1100_1101;
endpackage

module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int OPCODE_W   = 8,
    parameter int STATE_W    = 8,
    parameter int CYCLE_W    = 4,
    parameter int MAX_CYCLES = 8
) (
    input logic            clk,
    input logic            reset,
    cpu_sequencer_if.master bus
);

    generate
        if (MAX_CYCLES < 7 || MAX_CYCLES > 2**CYCLE_W) begin : g_bad_max_cycles
            $error("cpu_sequencer: MAX_CYCLES must lie in 7 .. 2**CYCLE_W");
        end
        if (OPCODE_W != 8) begin : g_bad_opcode_w
            $error("cpu_sequencer: opcode map is defined for OPCODE_W = 8");
        end
        if (STATE_W < 5) begin : g_bad_state_w
            $error("cpu_sequencer: STATE_W too narrow for the state codes");
        end
    endgenerate

    typedef enum logic [3:0] {
        CLS_NOP, CLS_HLT, CLS_OUT, CLS_ALU, CLS_LDI,
        CLS_JMP, CLS_MOV, CLS_RET, CLS_CALL
    } instr_class_e;

    typedef enum logic {MODE_RUN, MODE_HALTED} seq_mode_e;

    typedef struct packed {
        logic [7:0] code;
        logic [2:0] len;
    } step_t;

    function automatic instr_class_e decode(input logic [OPCODE_W-1:0] op);
        instr_class_e cls;
        casez (op)
            PATTERN_LDI: cls = CLS_LDI;
            PATTERN_MOV: cls = CLS_MOV;
            PATTERN_ALU: cls = CLS_ALU;
            PATTERN_JMP: cls = CLS_JMP;
            OP_HLT:      cls = CLS_HLT;
            OP_OUT:      cls = CLS_OUT;
            OP_RET:      cls = CLS_RET;
            OP_CALL:     cls = CLS_CALL;
            default:     cls = CLS_NOP;
        endcase
        return cls;
    endfunction

    // Step code at index idx of the class's list, plus the list's total length.
    function automatic step_t lookup(input instr_class_e cls, input int idx);
        step_t s;
        s.code = STATE_NEXT;
        s.len  = 3'd3;
        case (cls)
            CLS_LDI, CLS_JMP: s.len = 3'd4;
            CLS_MOV, CLS_RET: s.len = 3'd5;
            CLS_CALL:         s.len = 3'd7;
            default:          s.len = 3'd3;
        endcase
        if (idx == 0) begin
            s.code = STATE_FETCH_PC;
        end else if (idx == 1) begin
            s.code = STATE_FETCH_INST;
        end else begin
            case (cls)
                CLS_HLT: if (idx == 2) s.code = STATE_HALT;
                CLS_OUT: if (idx == 2) s.code = STATE_OUT_A;
                CLS_ALU: if (idx == 2) s.code = STATE_ALU_OP;
                CLS_LDI: begin
                    if (idx == 2) s.code = STATE_FETCH_PC;
                    if (idx == 3) s.code = STATE_LDI;
                end
                CLS_JMP: begin
                    if (idx == 2) s.code = STATE_FETCH_PC;
                    if (idx == 3) s.code = STATE_JUMP;
                end
                CLS_MOV: begin
                    if (idx == 2) s.code = STATE_MOV_FETCH;
                    if (idx == 3) s.code = STATE_MOV_LOAD;
                    if (idx == 4) s.code = STATE_MOV_STORE;
                end
                CLS_RET: begin
                    if (idx == 2) s.code = STATE_INC_SP;
                    if (idx == 3) s.code = STATE_FETCH_SP;
                    if (idx == 4) s.code = STATE_RET;
                end
                CLS_CALL: begin
                    if (idx == 2) s.code = STATE_FETCH_PC;
                    if (idx == 3) s.code = STATE_TMP_STORE;
                    if (idx == 4) s.code = STATE_FETCH_SP;
                    if (idx == 5) s.code = STATE_PC_STORE;
                    if (idx == 6) s.code = STATE_TMP_JUMP;
                end
                default: s.code = STATE_NEXT;
            endcase
        end
        return s;
    endfunction

    seq_mode_e          mode_q, mode_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic               done_q, done_d;

    instr_class_e cls;
    step_t        step;
    int           cyc;
    logic         past_end;
`ifdef CPU_SEQ_FIXED_LEN_EN
    logic         slot_last;
`else
    logic         real_last;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        mode_d   = mode_q;
        state_d  = state_q;
        cycle_d  = cycle_q;
        done_d   = 1'b0;
        cls      = decode(bus.opcode);
        cyc      = int'(cycle_q);
        step     = lookup(cls, cyc);
        past_end = (cyc >= int'(step.len));
`ifdef CPU_SEQ_FIXED_LEN_EN
        slot_last = (cyc == MAX_CYCLES - 1);
`else
        real_last = (cyc == int'(step.len) - 1);
`endif

        if (mode_q == MODE_HALTED) begin
            state_d = STATE_W'(STATE_HALT);
            cycle_d = '0;
        end else if (bus.restart) begin
            state_d = STATE_W'(STATE_NEXT);
            cycle_d = '0;
        end else if (!bus.stall) begin
`ifdef CPU_SEQ_FIXED_LEN_EN
            if (cyc > MAX_CYCLES - 1) begin
                state_d = STATE_W'(STATE_NEXT);
                cycle_d = '0;
                done_d  = 1'b1;
            end else if (!past_end && step.code == STATE_HALT) begin
                mode_d  = MODE_HALTED;
                state_d = STATE_W'(STATE_HALT);
                cycle_d = '0;
                done_d  = 1'b1;
            end else begin
                // Slots after the last real step are padded with NEXT.
                state_d = past_end ? STATE_W'(STATE_NEXT) : STATE_W'(step.code);
                cycle_d = slot_last ? '0 : cycle_q + CYCLE_W'(1);
                done_d  = slot_last;
            end
`else
            // Counter safety wrap: out of range, or the final slot is not a last step.
            if (cyc > MAX_CYCLES - 1 || past_end ||
                (cyc == MAX_CYCLES - 1 && !real_last)) begin
                state_d = STATE_W'(STATE_NEXT);
                cycle_d = '0;
                done_d  = 1'b1;
            end else if (step.code == STATE_HALT) begin
                mode_d  = MODE_HALTED;
                state_d = STATE_W'(STATE_HALT);
                cycle_d = '0;
                done_d  = 1'b1;
            end else begin
                state_d = STATE_W'(step.code);
                cycle_d = real_last ? '0 : cycle_q + CYCLE_W'(1);
                done_d  = real_last;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= MODE_RUN;
            state_q <= STATE_W'(STATE_NEXT);
            cycle_q <= '0;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            state_q <= state_d;
            cycle_q <= cycle_d;
            done_q  <= done_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.cycle      = cycle_q;
    assign bus.instr_done = done_q;
    assign bus.halted     = (mode_q == MODE_HALTED);

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Parametrised successor to the CPU control sequencer. Decodes the current opcode into instruction classes and issues one micro-step state per clock: 2 fetch steps, then the class-specific steps. Each instruction ends on its last real step instead of padding to a fixed 8 cycles. Adds stall and restart inputs, a sticky halt flag, and an end-of-instruction pulse. Sits between the instruction register and the datapath control decode.

Parameters:
OPCODE_W, 8, opcode width
STATE_W, 8, width of state codes (STATE_* from shared parameters include)
CYCLE_W, 4, width of cycle counter
MAX_CYCLES, 8, cycle slots per instruction; elaboration error if < 7 or > 2**CYCLE_W

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
opcode  in  OPCODE_W  instruction register contents; stable from cycle 2 of each instruction
stall  in  1  hold all registers this clock (memory/bus not ready)
restart  in  1  sync abort of current instruction; resume at fetch
state  out  STATE_W  registered micro-step code
cycle  out  CYCLE_W  index of the next step to issue
instr_done  out  1  one-clock pulse coincident with the last step of an instruction
halted  out  1  sticky; set when STATE_HALT issued

Behaviour:
- Priority per edge: reset > halted-hold > restart > stall > normal advance.
- Reset: state=STATE_NEXT, cycle=0, instr_done=0, halted=0.
- Decode via PATTERN_LDI/MOV/ALU/JMP casez, else exact OP_HLT/OUT/RET/CALL, else NOP.
- Normal edge: state <= step(cycle, class); cycle <= (step is last) ? 0 : cycle+1; instr_done <= (step is last).
- Step lists: steps 0,1 are FETCH_PC, FETCH_INST for every class. Then:
  - HLT: HALT
  - OUT: OUT_A
  - ALU: ALU_OP
  - NOP: NEXT
  - LDI: FETCH_PC, LDI
  - JMP: FETCH_PC, JUMP
  - MOV: MOV_FETCH, MOV_LOAD, MOV_STORE
  - RET: INC_SP, FETCH_SP, RET
  - CALL: FETCH_PC, TMP_STORE, FETCH_SP, PC_STORE, TMP_JUMP
- Instruction lengths (edges): HLT/OUT/ALU/NOP 3; LDI/JMP 4; MOV/RET 5; CALL 7.
- Back-to-back instructions: the edge after instr_done issues FETCH_PC at cycle 0, with no gap.
- Halt: on the edge issuing HALT, halted<=1 and instr_done<=1. Afterwards state stays STATE_HALT, cycle stays 0 and instr_done stays 0. Restart and stall are ignored while halted. Only reset clears halted.
- Stall: state, cycle and halted hold; instr_done forced 0. Stall on the last step delays the pulse until the step is actually issued.
- Restart: cycle<=0, state<=STATE_NEXT, instr_done<=0. The next unstalled edge issues FETCH_PC.
- Reset or restart mid-instruction: partial step sequence abandoned, no instr_done.
- Counter safety: cycle never exceeds MAX_CYCLES-1. Reaching it without a last step forces state=NEXT, cycle=0, instr_done=1 (unreachable for legal MAX_CYCLES).
- Unknown cycle value: no $display. Treat as the safety wrap above.

Optional Feature:
CPU_SEQ_FIXED_LEN_EN
- Defined: legacy timing. After its last real step, every instruction issues STATE_NEXT until cycle MAX_CYCLES-1. instr_done pulses only on the MAX_CYCLES-1 step, so every non-halt instruction takes exactly MAX_CYCLES edges.
- Undefined: variable-length behaviour as above.

Test Plan:
- Reset 2 clocks, opcode=OP_OUT -> states FETCH_PC, FETCH_INST, OUT_A; instr_done high only with OUT_A; next edge FETCH_PC, cycle=1.
- opcode=OP_CALL -> 7 states in listed order; cycle outputs 1..6 then 0; exactly one instr_done pulse.
- PATTERN_LDI opcode, stall=1 for 3 clocks during cycle 3 -> LDI held off 3 clocks, state/cycle unchanged while stalled, one instr_done after release.
- MOV with restart asserted at cycle 3 -> state=STATE_NEXT, cycle=0, no instr_done; next edge FETCH_PC.
- OP_HLT, then restart=1 and stall toggling -> halted=1 and state=STATE_HALT held; reset -> halted=0, state=STATE_NEXT, cycle=0.
- CPU_SEQ_FIXED_LEN_EN defined, PATTERN_ALU opcode -> FETCH_PC, FETCH_INST, ALU_OP, then 5x NEXT; instr_done on the 8th edge only.
